// File: rtl/clz_pkg.sv
// Shared types and helpers for the leading-symbol counter.
// Mode enum and count-width helper used by the pipe and its interface.
package clz_pkg;

  typedef enum logic {
    CLZ_ZEROS = 1'b0,
    CLZ_ONES  = 1'b1
  } clz_mode_e;

  function automatic int clz_cnt_w(int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/clz_norm_pipe_if.sv
// Valid/ready bundle for clz_norm_pipe: operand side and result side.
// master drives operands and out_ready; slave is the pipe.
interface clz_norm_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  import clz_pkg::*;

  localparam int CW = clz_cnt_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  clz_mode_e        in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_all;
  logic [WIDTH-1:0] out_norm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_count, out_all,
    input  out_norm, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_count, out_all,
    output out_norm, out_tag
  );

endinterface

// File: rtl/clz_tree.sv
// Combinational leading-zero counter built by recursive halving.
// Count width is $clog2(WIDTH)+1 so a fully zero operand reads WIDTH.
module clz_tree #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]     data,
  output logic [$clog2(WIDTH):0] count
);

  if (WIDTH == 2) begin : g_leaf
    assign count = data[1] ? 2'd0 :
                   data[0] ? 2'd1 : 2'd2;
  end else begin : g_node
    localparam int H  = WIDTH / 2;
    localparam int HW = $clog2(H) + 1;

    logic [HW-1:0] ch;
    logic [HW-1:0] cl;

    clz_tree #(.WIDTH(H)) u_hi (
      .data  (data[WIDTH-1:H]),
      .count (ch)
    );

    clz_tree #(.WIDTH(H)) u_lo (
      .data  (data[H-1:0]),
      .count (cl)
    );

    // ch saturates at H, a lone MSB, so that bit flags an all-zero upper half
    assign count = ch[HW-1] ? ({1'b0, ch} + {1'b0, cl})
                            : {1'b0, ch};
  end

endmodule

// File: rtl/clz_norm_pipe.sv
// Pipelined leading-zero/one counter with left normaliser and tag sideband.
// 0, 1 or 2 register stages with per-stage valid/ready backpressure.
module clz_norm_pipe
  import clz_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input logic            clk,
  input logic            rst,
  clz_norm_pipe_if.slave bus
);

  localparam int CW = clz_cnt_w(WIDTH);

  logic [WIDTH-1:0] sym;
  logic [CW-1:0]    cnt;
  logic             all_c;

  assign sym = (bus.in_mode == CLZ_ONES) ? ~bus.in_data
                                         : bus.in_data;

  clz_tree #(.WIDTH(WIDTH)) u_tree (
    .data  (sym),
    .count (cnt)
  );

  assign all_c = (cnt == CW'(WIDTH));

  // Top shift step is WIDTH itself, so count==WIDTH flushes to zero
  function automatic logic [WIDTH-1:0] norm_f(
    input logic [WIDTH-1:0] d,
    input logic [CW-1:0]    n
  );
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < CW; k++)
      if (n[k]) r = r << (1 << k);
    return r;
  endfunction

  if (PIPE_STAGES == 0) begin : g_comb
    assign bus.in_ready  = bus.out_ready;
    assign bus.out_valid = bus.in_valid;
    assign bus.out_count = cnt;
    assign bus.out_all   = all_c;
    assign bus.out_norm  = norm_f(bus.in_data, cnt);
    assign bus.out_tag   = bus.in_tag;
  end else if (PIPE_STAGES == 1) begin : g_one
    logic             v_b;
    logic [CW-1:0]    c_b;
    logic             a_b;
    logic [WIDTH-1:0] n_b;
    logic [TAG_W-1:0] t_b;
    logic             ready_b;

    assign ready_b      = !v_b || bus.out_ready;
    assign bus.in_ready = ready_b && !rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_b <= 1'b0;
        c_b <= '0;
        a_b <= 1'b0;
        n_b <= '0;
        t_b <= '0;
      end else if (ready_b) begin
        v_b <= bus.in_valid;
        if (bus.in_valid) begin
          c_b <= cnt;
          a_b <= all_c;
          n_b <= norm_f(bus.in_data, cnt);
          t_b <= bus.in_tag;
        end
      end
    end

    assign bus.out_valid = v_b;
    assign bus.out_count = c_b;
    assign bus.out_all   = a_b;
    assign bus.out_norm  = n_b;
    assign bus.out_tag   = t_b;
  end else begin : g_two
    logic             v_a;
    logic [CW-1:0]    c_a;
    logic             a_a;
    logic [WIDTH-1:0] d_a;
    logic [TAG_W-1:0] t_a;
    logic             ready_a;

    logic             v_b;
    logic [CW-1:0]    c_b;
    logic             a_b;
    logic [WIDTH-1:0] n_b;
    logic [TAG_W-1:0] t_b;
    logic             ready_b;

    assign ready_b      = !v_b || bus.out_ready;
    assign ready_a      = !v_a || ready_b;
    assign bus.in_ready = ready_a && !rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_a <= 1'b0;
        c_a <= '0;
        a_a <= 1'b0;
        d_a <= '0;
        t_a <= '0;
      end else if (ready_a) begin
        v_a <= bus.in_valid;
        if (bus.in_valid) begin
          c_a <= cnt;
          a_a <= all_c;
          d_a <= bus.in_data;
          t_a <= bus.in_tag;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_b <= 1'b0;
        c_b <= '0;
        a_b <= 1'b0;
        n_b <= '0;
        t_b <= '0;
      end else if (ready_b) begin
        v_b <= v_a;
        if (v_a) begin
          c_b <= c_a;
          a_b <= a_a;
          n_b <= norm_f(d_a, c_a);
          t_b <= t_a;
        end
      end
    end

    assign bus.out_valid = v_b;
    assign bus.out_count = c_b;
    assign bus.out_all   = a_b;
    assign bus.out_norm  = n_b;
    assign bus.out_tag   = t_b;
  end

endmodule

// File: tb/tb_clz_norm_pipe.sv
// Directed bench for clz_norm_pipe: main 64-bit 2-stage instance plus
// 0/1-stage and 32/128-bit instances swept alongside it.
module tb_clz_norm_pipe;
  import clz_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   errs;

  clz_norm_pipe_if #(.WIDTH(64),  .TAG_W(4)) bm ();
  clz_norm_pipe_if #(.WIDTH(64),  .TAG_W(4)) b0 ();
  clz_norm_pipe_if #(.WIDTH(64),  .TAG_W(4)) b1 ();
  clz_norm_pipe_if #(.WIDTH(32),  .TAG_W(4)) b32 ();
  clz_norm_pipe_if #(.WIDTH(128), .TAG_W(4)) b128 ();

  clz_norm_pipe #(.WIDTH(64), .PIPE_STAGES(2), .TAG_W(4))
    u_main (.clk(clk), .rst(rst), .bus(bm));
  clz_norm_pipe #(.WIDTH(64), .PIPE_STAGES(0), .TAG_W(4))
    u_p0 (.clk(clk), .rst(rst), .bus(b0));
  clz_norm_pipe #(.WIDTH(64), .PIPE_STAGES(1), .TAG_W(4))
    u_p1 (.clk(clk), .rst(rst), .bus(b1));
  clz_norm_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4))
    u_w32 (.clk(clk), .rst(rst), .bus(b32));
  clz_norm_pipe #(.WIDTH(128), .PIPE_STAGES(2), .TAG_W(4))
    u_w128 (.clk(clk), .rst(rst), .bus(b128));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int e_cnt(int w, int i);
    return (i < w) ? (w - 1 - i) : w;
  endfunction

  function automatic logic [127:0] e_norm(int w, int i);
    logic [127:0] one;
    one = 128'd1;
    return (i < w) ? (one << (w - 1)) : 128'd0;
  endfunction

  task automatic drive_all(input logic v,
                           input logic [127:0] d,
                           input logic [3:0] t);
    bm.in_valid = v;   bm.in_data = d[63:0];
    b0.in_valid = v;   b0.in_data = d[63:0];
    b1.in_valid = v;   b1.in_data = d[63:0];
    b32.in_valid = v;  b32.in_data = d[31:0];
    b128.in_valid = v; b128.in_data = d;
    bm.in_tag = t; b0.in_tag = t; b1.in_tag = t;
    b32.in_tag = t; b128.in_tag = t;
  endtask

  int sent, rcv, c;
  logic saw_block, hold;
  logic [3:0] htag;
  logic [6:0] hcnt;
  logic [63:0] hnorm;
  logic [127:0] v;

  initial begin
    vectors = 0;
    errs    = 0;
    rst     = 1'b1;
    drive_all(1'b0, 128'd0, 4'd0);
    bm.in_mode = CLZ_ZEROS;   b0.in_mode = CLZ_ZEROS;
    b1.in_mode = CLZ_ZEROS;   b32.in_mode = CLZ_ZEROS;
    b128.in_mode = CLZ_ZEROS;
    bm.out_ready = 1'b1;   b0.out_ready = 1'b1;
    b1.out_ready = 1'b1;   b32.out_ready = 1'b1;
    b128.out_ready = 1'b1;

    // reset held 3 cycles with in_valid high
    bm.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("rst_out_valid", bm.out_valid, 1'b0);
      chk("rst_in_ready", bm.in_ready, 1'b0);
    end
    chk("rst_count", bm.out_count, 0);
    chk("rst_all", bm.out_all, 1'b0);
    chk("rst_norm", bm.out_norm, 0);
    chk("rst_tag", bm.out_tag, 0);
    chk("rst_p1_valid", b1.out_valid, 1'b0);
    rst = 1'b0;
    bm.in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", bm.in_ready, 1'b1);
    chk("post_rst_p1_ready", b1.in_ready, 1'b1);
    chk("p0_ready_follow", b0.in_ready, 1'b1);
    step;

    // one-hot sweep, i==128 gives an all-zero operand everywhere
    for (int i = 0; i <= 128; i++) begin
      v = 128'd1 << i;
      drive_all(1'b1, v, i[3:0]);
      #1;
      chk("sw_ready", bm.in_ready, 1'b1);
      chk("p0_valid", b0.out_valid, 1'b1);
      chk("p0_count", b0.out_count, e_cnt(64, i));
      chk("p0_all", b0.out_all, i >= 64);
      chk("p0_norm", b0.out_norm, e_norm(64, i));
      step;
      drive_all(1'b0, 128'd0, 4'd0);
      #1;
      chk("p1_valid", b1.out_valid, 1'b1);
      chk("p1_count", b1.out_count, e_cnt(64, i));
      chk("p1_norm", b1.out_norm, e_norm(64, i));
      chk("p1_tag", b1.out_tag, i % 16);
      chk("sw_lat_early", bm.out_valid, 1'b0);
      step;
      chk("sw_valid", bm.out_valid, 1'b1);
      chk("sw_count", bm.out_count, e_cnt(64, i));
      chk("sw_all", bm.out_all, i >= 64);
      chk("sw_norm", bm.out_norm, e_norm(64, i));
      chk("sw_tag", bm.out_tag, i % 16);
      chk("w32_count", b32.out_count, e_cnt(32, i));
      chk("w32_all", b32.out_all, i >= 32);
      chk("w32_norm", b32.out_norm, e_norm(32, i));
      chk("w128_count", b128.out_count, e_cnt(128, i));
      chk("w128_all", b128.out_all, i >= 128);
      chk("w128_norm", b128.out_norm, e_norm(128, i));
      chk("p1_bubble", b1.out_valid, 1'b0);
      step;
      chk("sw_drain", bm.out_valid, 1'b0);
    end

    // leading-ones mode
    bm.in_mode  = CLZ_ONES;
    bm.in_valid = 1'b1;
    bm.in_data  = 64'hFFF0_0000_0000_0001;
    bm.in_tag   = 4'd5;
    step;
    bm.in_valid = 1'b0;
    step;
    chk("ones_valid", bm.out_valid, 1'b1);
    chk("ones_count", bm.out_count, 12);
    chk("ones_all", bm.out_all, 1'b0);
    chk("ones_norm", bm.out_norm, 64'h0000_0000_0000_1000);
    chk("ones_tag", bm.out_tag, 5);
    step;
    bm.in_valid = 1'b1;
    bm.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    bm.in_tag   = 4'd6;
    step;
    bm.in_valid = 1'b0;
    step;
    chk("ones_full_count", bm.out_count, 64);
    chk("ones_full_all", bm.out_all, 1'b1);
    chk("ones_full_norm", bm.out_norm, 0);
    chk("ones_full_tag", bm.out_tag, 6);
    step;
    bm.in_mode = CLZ_ZEROS;

    // backpressure: out_ready low on stream cycles 3..6
    sent = 0; rcv = 0; saw_block = 0; hold = 0;
    htag = 0; hcnt = 0; hnorm = 0;
    for (c = 0; c < 40 && rcv < 8; c++) begin
      bm.out_ready = !(c >= 3 && c <= 6);
      bm.in_valid  = (sent < 8);
      bm.in_data   = 64'd1 << sent;
      bm.in_tag    = sent[3:0];
      #1;
      if (hold) begin
        chk("bp_hold_valid", bm.out_valid, 1'b1);
        chk("bp_hold_tag", bm.out_tag, htag);
        chk("bp_hold_count", bm.out_count, hcnt);
        chk("bp_hold_norm", bm.out_norm, hnorm);
      end
      if (sent < 8 && !bm.in_ready) saw_block = 1;
      if (bm.out_valid && bm.out_ready) begin
        chk("bp_tag", bm.out_tag, rcv);
        chk("bp_count", bm.out_count, 63 - rcv);
        rcv++;
      end
      hold  = bm.out_valid && !bm.out_ready;
      htag  = bm.out_tag;
      hcnt  = bm.out_count;
      hnorm = bm.out_norm;
      if (bm.in_valid && bm.in_ready) sent++;
      step;
    end
    chk("bp_received", rcv, 8);
    chk("bp_in_ready_drop", saw_block, 1'b1);
    bm.in_valid  = 1'b0;
    bm.out_ready = 1'b1;
    step;
    step;
    chk("bp_empty", bm.out_valid, 1'b0);

    // throughput: 16 back-to-back beats, first result on cycle 2
    sent = 0; rcv = 0;
    for (c = 0; c < 40 && rcv < 16; c++) begin
      bm.in_valid = (sent < 16);
      bm.in_data  = 64'h8000_0000_0000_0000 >> sent;
      bm.in_tag   = sent[3:0];
      #1;
      if (sent < 16) chk("tp_in_ready", bm.in_ready, 1'b1);
      if (bm.out_valid) begin
        chk("tp_cycle", c, 2 + rcv);
        chk("tp_tag", bm.out_tag, rcv);
        chk("tp_count", bm.out_count, rcv);
        rcv++;
      end
      if (bm.in_valid && bm.in_ready) sent++;
      step;
    end
    chk("tp_received", rcv, 16);
    bm.in_valid = 1'b0;
    step;
    step;

    // reset with two beats in flight
    bm.out_ready = 1'b0;
    bm.in_valid  = 1'b1;
    bm.in_data   = 64'd1;
    bm.in_tag    = 4'd9;
    step;
    bm.in_tag    = 4'd10;
    step;
    bm.in_valid  = 1'b0;
    #1;
    chk("mr_in_flight", bm.out_valid, 1'b1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    bm.out_ready = 1'b1;
    #1;
    chk("mr_flushed", bm.out_valid, 1'b0);
    chk("mr_in_ready", bm.in_ready, 1'b1);
    bm.in_valid = 1'b1;
    bm.in_data  = 64'd1 << 40;
    bm.in_tag   = 4'd11;
    step;
    bm.in_valid = 1'b0;
    #1;
    chk("mr_lat1", bm.out_valid, 1'b0);
    step;
    chk("mr_valid", bm.out_valid, 1'b1);
    chk("mr_tag", bm.out_tag, 11);
    chk("mr_count", bm.out_count, 23);
    chk("mr_norm", bm.out_norm, 64'h8000_0000_0000_0000);
    step;
    chk("mr_after", bm.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
